// File: rtl/tpu_mmio_host.sv
// MMIO initiator that runs one matrix job on the TPU register map: load A/B, start, poll, read C, clear.
// Optional ID register check before the job is enabled by defining TPU_HOST_ID_CHECK_EN.

// state  | meaning
// IDLE   | waiting for job_start
// CHK_ID | reading ID register (TPU_HOST_ID_CHECK_EN only)
// WR_A   | writing A elements 0..E-1
// WR_B   | writing B elements 0..E-1
// START  | writing CTRL = 1
// POLL   | reading STATUS until done or poll budget exhausted
// SETTLE | idle gap before the first C read
// RD_C   | reading C elements 0..E-1 into c_res_flat
// CLEAR  | writing CTRL = 2, then job_done
module tpu_mmio_host #(
    parameter int          N             = 4,
    parameter int          DATA_W        = 8,
    parameter int          SUM_W         = 32,
    parameter logic [15:0] TPU_BASE      = 16'h0000,
    parameter int          POLL_TIMEOUT  = 1024,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] EXPECT_ID     = 32'h5450_0001
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   job_start,
    input  logic [DATA_W*N*N-1:0]  a_src_flat,
    input  logic [DATA_W*N*N-1:0]  b_src_flat,
    output logic [SUM_W*N*N-1:0]   c_res_flat,
    output logic                   busy,
    output logic                   job_done,
    output logic                   err_timeout,
    output logic                   err_id,
    output logic                   mmio_wr,
    output logic                   mmio_rd,
    output logic [15:0]            mmio_addr,
    output logic [31:0]            mmio_wdata,
    output logic [3:0]             mmio_wstrb,
    input  logic [31:0]            mmio_rdata,
    input  logic                   mmio_ready
);
    localparam int E     = N * N;
    localparam int IDX_W = (E > 1) ? $clog2(E) : 1;
    localparam int PW    = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;
    localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [15:0] ID_ADDR   = TPU_BASE;
    localparam logic [15:0] CTRL_ADDR = TPU_BASE + 16'h0008;
    localparam logic [15:0] STAT_ADDR = TPU_BASE + 16'h000C;
    localparam logic [15:0] A_BASE    = TPU_BASE + 16'h0100;
    localparam logic [15:0] B_BASE    = TPU_BASE + 16'h0200;
    localparam logic [15:0] C_BASE    = TPU_BASE + 16'h0300;

    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(E - 1);
    localparam logic [PW-1:0]    POLL_LOAD   = PW'(POLL_TIMEOUT - 1);
    localparam logic [SW-1:0]    SETTLE_LOAD = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [3:0] {
        IDLE,
`ifdef TPU_HOST_ID_CHECK_EN
        CHK_ID,
`endif
        WR_A,
        WR_B,
        START,
        POLL,
        SETTLE,
        RD_C,
        CLEAR
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d, idx_inc;
    logic [PW-1:0]          poll_q, poll_d;
    logic [SW-1:0]          settle_q, settle_d;
    logic                   wr_d, rd_d, busy_d, done_d, err_to_d;
    logic [15:0]            addr_d;
    logic [31:0]            wdata_d;
    logic [3:0]             wstrb_d;
    logic [SUM_W*E-1:0]     c_res_d;
    logic [31:0]            a_first, a_next, b_first, b_next;
    logic                   xfer;

    assign idx_inc = idx_q + 1'b1;
    assign a_first = 32'(a_src_flat[0 +: DATA_W]);
    assign b_first = 32'(b_src_flat[0 +: DATA_W]);
    assign a_next  = 32'(a_src_flat[int'(idx_inc)*DATA_W +: DATA_W]);
    assign b_next  = 32'(b_src_flat[int'(idx_inc)*DATA_W +: DATA_W]);
    assign xfer    = (mmio_wr | mmio_rd) & mmio_ready;

`ifdef TPU_HOST_ID_CHECK_EN
    logic err_id_q, err_id_d;
    assign err_id = err_id_q;
`else
    assign err_id = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        poll_d   = poll_q;
        settle_d = settle_q;
        wr_d     = mmio_wr;
        rd_d     = mmio_rd;
        addr_d   = mmio_addr;
        wdata_d  = mmio_wdata;
        busy_d   = busy;
        done_d   = 1'b0;
        err_to_d = err_timeout;
        c_res_d  = c_res_flat;
`ifdef TPU_HOST_ID_CHECK_EN
        err_id_d = err_id_q;
`endif
        case (state_q)
            IDLE: begin
                // a start coinciding with the previous job's done pulse is dropped
                if (job_start && !job_done) begin
                    busy_d   = 1'b1;
                    err_to_d = 1'b0;
                    idx_d    = '0;
`ifdef TPU_HOST_ID_CHECK_EN
                    err_id_d = 1'b0;
                    state_d  = CHK_ID;
                    rd_d     = 1'b1;
                    addr_d   = ID_ADDR;
`else
                    state_d  = WR_A;
                    wr_d     = 1'b1;
                    addr_d   = A_BASE;
                    wdata_d  = a_first;
`endif
                end
            end
`ifdef TPU_HOST_ID_CHECK_EN
            CHK_ID: if (xfer) begin
                rd_d = 1'b0;
                if (mmio_rdata != EXPECT_ID) begin
                    err_id_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = WR_A;
                    wr_d    = 1'b1;
                    addr_d  = A_BASE;
                    wdata_d = a_first;
                end
            end
`endif
            WR_A: if (xfer) begin
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = WR_B;
                    addr_d  = B_BASE;
                    wdata_d = b_first;
                end else begin
                    idx_d   = idx_inc;
                    addr_d  = A_BASE + 16'(idx_inc);
                    wdata_d = a_next;
                end
            end
            WR_B: if (xfer) begin
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = START;
                    addr_d  = CTRL_ADDR;
                    wdata_d = 32'h1;
                end else begin
                    idx_d   = idx_inc;
                    addr_d  = B_BASE + 16'(idx_inc);
                    wdata_d = b_next;
                end
            end
            START: if (xfer) begin
                wr_d    = 1'b0;
                rd_d    = 1'b1;
                addr_d  = STAT_ADDR;
                poll_d  = POLL_LOAD;
                state_d = POLL;
            end
            POLL: if (xfer) begin
                if (mmio_rdata[1]) begin
                    idx_d    = '0;
                    settle_d = SETTLE_LOAD;
                    if (SETTLE_CYCLES == 0) begin
                        state_d = RD_C;
                        addr_d  = C_BASE;
                    end else begin
                        rd_d    = 1'b0;
                        state_d = SETTLE;
                    end
                end else if (poll_q == '0) begin
                    err_to_d = 1'b1;
                    rd_d     = 1'b0;
                    wr_d     = 1'b1;
                    addr_d   = CTRL_ADDR;
                    wdata_d  = 32'h2;
                    state_d  = CLEAR;
                end else begin
                    poll_d = poll_q - 1'b1;
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = RD_C;
                    rd_d    = 1'b1;
                    addr_d  = C_BASE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            RD_C: if (xfer) begin
                c_res_d[int'(idx_q)*SUM_W +: SUM_W] = SUM_W'(mmio_rdata);
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b1;
                    addr_d  = CTRL_ADDR;
                    wdata_d = 32'h2;
                    state_d = CLEAR;
                end else begin
                    idx_d  = idx_inc;
                    addr_d = C_BASE + 16'({idx_inc, 2'b00});
                end
            end
            CLEAR: if (xfer) begin
                wr_d    = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        wstrb_d = wr_d ? 4'hF : 4'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            poll_q      <= '0;
            settle_q    <= '0;
            mmio_wr     <= 1'b0;
            mmio_rd     <= 1'b0;
            mmio_addr   <= '0;
            mmio_wdata  <= '0;
            mmio_wstrb  <= '0;
            busy        <= 1'b0;
            job_done    <= 1'b0;
            err_timeout <= 1'b0;
            c_res_flat  <= '0;
`ifdef TPU_HOST_ID_CHECK_EN
            err_id_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            poll_q      <= poll_d;
            settle_q    <= settle_d;
            mmio_wr     <= wr_d;
            mmio_rd     <= rd_d;
            mmio_addr   <= addr_d;
            mmio_wdata  <= wdata_d;
            mmio_wstrb  <= wstrb_d;
            busy        <= busy_d;
            job_done    <= done_d;
            err_timeout <= err_to_d;
            c_res_flat  <= c_res_d;
`ifdef TPU_HOST_ID_CHECK_EN
            err_id_q    <= err_id_d;
`endif
        end
    end

endmodule

// File: tb/tb_tpu_mmio_host.sv
// Directed bench for tpu_mmio_host with a small accelerator register model on the MMIO side.
// Define TPU_HOST_ID_CHECK_EN to build the ID-check variant and its mismatch scenario.
module tb_tpu_mmio_host;
    localparam int N = 4;
    localparam int E = 16;
    localparam int DATA_W = 8;
    localparam int SUM_W = 32;
    localparam int PT = 8;
    localparam logic [31:0] EXP_ID = 32'h5450_0001;
`ifdef TPU_HOST_ID_CHECK_EN
    localparam int LAT_EXP = 57;
`else
    localparam int LAT_EXP = 56;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic job_start = 1'b0;
    logic [DATA_W*E-1:0] a_src_flat = '0;
    logic [DATA_W*E-1:0] b_src_flat = '0;
    logic [SUM_W*E-1:0] c_res_flat;
    logic busy, job_done, err_timeout, err_id, mmio_wr, mmio_rd;
    logic [15:0] mmio_addr;
    logic [31:0] mmio_wdata, mmio_rdata;
    logic [3:0] mmio_wstrb;
    logic mmio_ready = 1'b1;

    always #5 clk = ~clk;

    tpu_mmio_host #(.N(N), .DATA_W(DATA_W), .SUM_W(SUM_W), .TPU_BASE(16'h0000),
                    .POLL_TIMEOUT(PT), .SETTLE_CYCLES(2), .EXPECT_ID(EXP_ID)) dut (
        .clk(clk), .rst_n(rst_n), .job_start(job_start),
        .a_src_flat(a_src_flat), .b_src_flat(b_src_flat), .c_res_flat(c_res_flat),
        .busy(busy), .job_done(job_done), .err_timeout(err_timeout), .err_id(err_id),
        .mmio_wr(mmio_wr), .mmio_rd(mmio_rd), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
        .mmio_wstrb(mmio_wstrb), .mmio_rdata(mmio_rdata), .mmio_ready(mmio_ready));

    int errors = 0;
    int checks = 0;
    int a_v[E];
    int b_v[E];
    bit rand_ready = 1'b0;
    bit never_done = 1'b0;
    int done_after = 3;
    logic [31:0] id_val = EXP_ID;

    typedef struct {bit wr; logic [15:0] addr; logic [31:0] data;} acc_t;
    acc_t log_q[$];
    acc_t exp_q[$];

    // accelerator model
    logic [7:0]  a_mod[E];
    logic [7:0]  b_mod[E];
    logic [31:0] c_mod[E];
    int stat_reads = 0;

    always_comb begin
        mmio_rdata = 32'h0;
        if (mmio_addr == 16'h0000) mmio_rdata = id_val;
        else if (mmio_addr == 16'h000C)
            mmio_rdata = (!never_done && stat_reads >= done_after - 1) ? 32'h2 : 32'h1;
        else if (mmio_addr >= 16'h0300 && mmio_addr < 16'h0340)
            mmio_rdata = c_mod[int'(mmio_addr - 16'h0300) >> 2];
    end

    // negedge snapshot of the bus; committed at the following posedge
    bit s_wr = 0, s_rd = 0, s_ready = 0;
    logic [15:0] s_addr = '0;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    int hold_viol = 0, hold_seen = 0, strb_viol = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if ((s_wr || s_rd) && !s_ready) begin
                hold_seen++;
                if ({mmio_wr, mmio_rd, mmio_addr, mmio_wdata, mmio_wstrb} !==
                    {s_wr, s_rd, s_addr, s_wdata, s_wstrb}) hold_viol++;
            end
            if (mmio_wstrb !== (mmio_wr ? 4'hF : 4'h0)) strb_viol++;
            if (job_done) done_cnt++;
        end
        s_wr = mmio_wr; s_rd = mmio_rd; s_ready = mmio_ready;
        s_addr = mmio_addr; s_wdata = mmio_wdata; s_wstrb = mmio_wstrb;
    end

    always @(posedge clk) begin
        int acc;
        if (rst_n) begin
            if (s_wr && s_ready) begin
                log_q.push_back('{1'b1, s_addr, s_wdata});
                if (s_addr >= 16'h0100 && s_addr < 16'h0110) a_mod[int'(s_addr - 16'h0100)] <= s_wdata[7:0];
                if (s_addr >= 16'h0200 && s_addr < 16'h0210) b_mod[int'(s_addr - 16'h0200)] <= s_wdata[7:0];
                if (s_addr == 16'h0008 && s_wdata == 32'h1) begin
                    stat_reads <= 0;
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++) begin
                            acc = 0;
                            for (int k = 0; k < N; k++) acc += int'(a_mod[r*N+k]) * int'(b_mod[k*N+c]);
                            c_mod[r*N+c] <= 32'(acc);
                        end
                end
            end
            if (s_rd && s_ready) begin
                log_q.push_back('{1'b0, s_addr, 32'h0});
                if (s_addr == 16'h000C) stat_reads <= stat_reads + 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        mmio_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_mats;
        for (int i = 0; i < E; i++) begin
            a_src_flat[i*DATA_W +: DATA_W] = DATA_W'(a_v[i]);
            b_src_flat[i*DATA_W +: DATA_W] = DATA_W'(b_v[i]);
        end
    endtask

    task automatic set_a_diag(input int d);
        for (int i = 0; i < E; i++) a_v[i] = (i % (N + 1) == 0) ? d : 0;
    endtask

    task automatic build_exp(input int k, input bit to);
`ifdef TPU_HOST_ID_CHECK_EN
        exp_q.push_back('{1'b0, 16'h0000, 32'h0});
`endif
        for (int i = 0; i < E; i++) exp_q.push_back('{1'b1, 16'h0100 + 16'(i), 32'(a_v[i])});
        for (int i = 0; i < E; i++) exp_q.push_back('{1'b1, 16'h0200 + 16'(i), 32'(b_v[i])});
        exp_q.push_back('{1'b1, 16'h0008, 32'h1});
        for (int j = 0; j < k; j++) exp_q.push_back('{1'b0, 16'h000C, 32'h0});
        if (!to) for (int i = 0; i < E; i++) exp_q.push_back('{1'b0, 16'h0300 + 16'(4*i), 32'h0});
        exp_q.push_back('{1'b1, 16'h0008, 32'h2});
    endtask

    function automatic int first_diff(input int start);
        int n = log_q.size() - start;
        int m = (n > exp_q.size()) ? n : exp_q.size();
        for (int j = 0; j < m; j++) begin
            if (j >= n || j >= exp_q.size()) return j;
            if (log_q[start+j].wr !== exp_q[j].wr || log_q[start+j].addr !== exp_q[j].addr ||
                log_q[start+j].data !== exp_q[j].data) return j;
        end
        return -1;
    endfunction

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!job_done && cyc < 2000) begin
            tick;
            cyc++;
        end
        checks++;
        if (job_done !== 1'b1) begin
            errors++;
            $display("FAIL done_wait: job_done=%b after %0d cycles, expected 1", job_done, cyc);
        end
    endtask

    task automatic run_job(output int lat);
        int cyc;
        job_start = 1'b1;
        tick;
        job_start = 1'b0;
        wait_done(cyc);
        lat = cyc + 1;
    endtask

    task automatic check_seq(input string name, input int ls);
        int fd = first_diff(ls);
        checks++;
        if (fd !== -1) begin
            errors++;
            $display("FAIL %s: accesses diverge at %0d, got %0d accesses, expected %0d",
                     name, fd, log_q.size() - ls, exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({mmio_wr, mmio_rd, mmio_addr, mmio_wdata, mmio_wstrb} !== 54'h0) begin
            errors++;
            $display("FAIL reset_bus: wr=%b rd=%b addr=%h wdata=%h wstrb=%h, expected all 0",
                     mmio_wr, mmio_rd, mmio_addr, mmio_wdata, mmio_wstrb);
        end
        checks++;
        if ({busy, job_done, err_timeout, err_id} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: busy/done/err_to/err_id=%b, expected 0000",
                     {busy, job_done, err_timeout, err_id});
        end
        checks++;
        if (c_res_flat !== '0) begin
            errors++;
            $display("FAIL reset_cres: c_res_flat=%h, expected 0", c_res_flat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        int lat, ls, d0;
        logic [SUM_W*E-1:0] ev;
        set_a_diag(1);
        for (int i = 0; i < E; i++) b_v[i] = i + 1;
        load_mats;
        exp_q.delete();
        build_exp(3, 1'b0);
        ls = log_q.size();
        d0 = done_cnt;
        run_job(lat);
        tick; tick; tick;
        for (int i = 0; i < E; i++) ev[i*SUM_W +: SUM_W] = 32'(i + 1);
        checks++;
        if (lat !== LAT_EXP) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, expected %0d", lat, LAT_EXP);
        end
        check_seq("basic_seq", ls);
        checks++;
        if (c_res_flat !== ev) begin
            errors++;
            $display("FAIL basic_cres: got %h expected %h", c_res_flat, ev);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL basic_done_pulses: got %0d, expected 1", done_cnt - d0);
        end
        checks++;
        if ({busy, err_timeout, err_id} !== 3'b000) begin
            errors++;
            $display("FAIL basic_flags: busy/err_to/err_id=%b, expected 000", {busy, err_timeout, err_id});
        end
        checks++;
        if (strb_viol !== 0) begin
            errors++;
            $display("FAIL basic_wstrb: %0d cycles with wrong wstrb, expected 0", strb_viol);
        end
    endtask

    task automatic test_ready_stall;
        int lat, ls, d0, h0, hv0;
        logic [SUM_W*E-1:0] ev;
        set_a_diag(3);
        for (int i = 0; i < E; i++) b_v[i] = i + 1;
        load_mats;
        exp_q.delete();
        build_exp(3, 1'b0);
        ls = log_q.size();
        d0 = done_cnt; h0 = hold_seen; hv0 = hold_viol;
        rand_ready = 1'b1;
        run_job(lat);
        rand_ready = 1'b0;
        tick; tick; tick;
        for (int i = 0; i < E; i++) ev[i*SUM_W +: SUM_W] = 32'(3 * (i + 1));
        check_seq("stall_seq", ls);
        checks++;
        if (c_res_flat !== ev) begin
            errors++;
            $display("FAIL stall_cres: got %h expected %h", c_res_flat, ev);
        end
        checks++;
        if (hold_viol - hv0 !== 0) begin
            errors++;
            $display("FAIL stall_hold: %0d stalled cycles changed the request, expected 0", hold_viol - hv0);
        end
        checks++;
        if (!(hold_seen > h0)) begin
            errors++;
            $display("FAIL stall_seen: got %0d stalled cycles, expected at least 1", hold_seen - h0);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL stall_done_pulses: got %0d, expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_timeout;
        int lat, ls, d0;
        logic [SUM_W*E-1:0] ev;
        never_done = 1'b1;
        exp_q.delete();
        build_exp(PT, 1'b1);
        ls = log_q.size();
        d0 = done_cnt;
        run_job(lat);
        tick; tick; tick;
        never_done = 1'b0;
        for (int i = 0; i < E; i++) ev[i*SUM_W +: SUM_W] = 32'(3 * (i + 1));
        check_seq("timeout_seq", ls);
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: err_timeout=%b, expected 1", err_timeout);
        end
        checks++;
        if (c_res_flat !== ev) begin
            errors++;
            $display("FAIL timeout_cres_held: got %h expected %h", c_res_flat, ev);
        end
        checks++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_done: pulses=%0d busy=%b, expected 1 and 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_restart_ignored;
        int ls, d0, cyc;
        logic [SUM_W*E-1:0] ev;
        set_a_diag(1);
        for (int i = 0; i < E; i++) b_v[i] = 2 * i + 1;
        load_mats;
        exp_q.delete();
        build_exp(3, 1'b0);
        ls = log_q.size();
        d0 = done_cnt;
        job_start = 1'b1;
        tick;
        job_start = 1'b0;
        cyc = 0;
        while (!(mmio_wr && mmio_addr == 16'h0205) && cyc < 500) begin
            tick;
            cyc++;
        end
        checks++;
        if (!(mmio_wr && mmio_addr == 16'h0205)) begin
            errors++;
            $display("FAIL restart_reach_wrb: addr=%h wr=%b, expected write to 0205", mmio_addr, mmio_wr);
        end
        job_start = 1'b1;
        tick;
        job_start = 1'b0;
        wait_done(cyc);
        tick; tick; tick;
        for (int i = 0; i < E; i++) ev[i*SUM_W +: SUM_W] = 32'(2 * i + 1);
        check_seq("restart_seq", ls);
        checks++;
        if (c_res_flat !== ev) begin
            errors++;
            $display("FAIL restart_cres: got %h expected %h", c_res_flat, ev);
        end
        checks++;
        if (done_cnt - d0 !== 1 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL restart_done: pulses=%0d err_timeout=%b, expected 1 and 0", done_cnt - d0, err_timeout);
        end
    endtask

    task automatic test_back_to_back;
        int lat, ls, cyc;
        logic [SUM_W*E-1:0] ev;
        set_a_diag(1);
        for (int i = 0; i < E; i++) b_v[i] = i + 1;
        load_mats;
        exp_q.delete();
        build_exp(3, 1'b0);
        ls = log_q.size();
        run_job(lat);
        job_start = 1'b1;
        tick;
        job_start = 1'b0;
        checks++;
        if (busy !== 1'b0 || mmio_wr !== 1'b0 || mmio_rd !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start_on_done: busy=%b wr=%b rd=%b, expected 0 0 0", busy, mmio_wr, mmio_rd);
        end
        for (int i = 0; i < E; i++) b_v[i] = 100 + i;
        load_mats;
        build_exp(3, 1'b0);
        job_start = 1'b1;
        tick;
        job_start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_start: busy=%b, expected 1", busy);
        end
        wait_done(cyc);
        tick; tick; tick;
        for (int i = 0; i < E; i++) ev[i*SUM_W +: SUM_W] = 32'(100 + i);
        check_seq("b2b_seq", ls);
        checks++;
        if (c_res_flat !== ev) begin
            errors++;
            $display("FAIL b2b_cres: got %h expected %h", c_res_flat, ev);
        end
    endtask

    task automatic test_reset_mid;
        int lat, ls, d0, cyc;
        logic [SUM_W*E-1:0] ev;
        set_a_diag(1);
        for (int i = 0; i < E; i++) b_v[i] = i + 1;
        load_mats;
        job_start = 1'b1;
        tick;
        job_start = 1'b0;
        cyc = 0;
        while (!(mmio_rd && mmio_addr == 16'h0314) && cyc < 500) begin
            tick;
            cyc++;
        end
        checks++;
        if (!(mmio_rd && mmio_addr == 16'h0314)) begin
            errors++;
            $display("FAIL rstmid_reach_c5: addr=%h rd=%b, expected read of 0314", mmio_addr, mmio_rd);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mmio_wr, mmio_rd, busy, job_done, err_timeout, err_id} !== 6'b0 ||
            {mmio_addr, mmio_wdata, mmio_wstrb} !== 52'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: wr=%b rd=%b busy=%b addr=%h wdata=%h, expected all 0",
                     mmio_wr, mmio_rd, busy, mmio_addr, mmio_wdata);
        end
        checks++;
        if (c_res_flat !== '0) begin
            errors++;
            $display("FAIL rstmid_cres: got %h expected 0", c_res_flat);
        end
        tick; tick;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        for (int i = 0; i < E; i++) b_v[i] = 50 + 2 * i;
        load_mats;
        exp_q.delete();
        build_exp(3, 1'b0);
        ls = log_q.size();
        d0 = done_cnt;
        run_job(lat);
        tick; tick; tick;
        for (int i = 0; i < E; i++) ev[i*SUM_W +: SUM_W] = 32'(50 + 2 * i);
        check_seq("rstmid_seq", ls);
        checks++;
        if (c_res_flat !== ev || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL rstmid_rerun: cres=%h pulses=%0d, expected %h and 1", c_res_flat, done_cnt - d0, ev);
        end
    endtask

`ifdef TPU_HOST_ID_CHECK_EN
    task automatic test_id_mismatch;
        int lat, ls, d0;
        id_val = 32'hDEAD_BEEF;
        exp_q.delete();
        exp_q.push_back('{1'b0, 16'h0000, 32'h0});
        ls = log_q.size();
        d0 = done_cnt;
        run_job(lat);
        tick; tick; tick;
        id_val = EXP_ID;
        check_seq("id_seq", ls);
        checks++;
        if (err_id !== 1'b1) begin
            errors++;
            $display("FAIL id_flag: err_id=%b, expected 1", err_id);
        end
        checks++;
        if (lat !== 2 || done_cnt - d0 !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL id_done: lat=%0d pulses=%0d busy=%b, expected 2 1 0", lat, done_cnt - d0, busy);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_ready_stall;
        test_timeout;
        test_restart_ignored;
        test_back_to_back;
        test_reset_mid;
`ifdef TPU_HOST_ID_CHECK_EN
        test_id_mismatch;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tpu_mmio_host.md
Name: tpu_mmio_host

Overview:
MMIO initiator that drives the TPU accelerator's register interface from the host side. For one job it loads matrix A and matrix B element-by-element, writes CTRL.start, polls STATUS until the done bit is set, reads back every C element into a flat result bus, then writes CTRL.clear_done. It sits between a test or SoC job source and the accelerator's mmio_* ports, and replaces hand-written bus sequences in system benches.

Parameters:
N, 4, matrix dimension; elements per matrix E = N*N
DATA_W, 8, A/B element width (DATA_W <= 32)
SUM_W, 32, C element width (must be 32)
TPU_BASE, 16'h0000, base address of the accelerator register map
POLL_TIMEOUT, 1024, maximum STATUS reads before the job aborts
SETTLE_CYCLES, 2, idle cycles between observing done and the first C read
EXPECT_ID, 32'h5450_0001, value compared against the ID register when ID checking is enabled

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
job_start  in  1  one-cycle request to run a job; ignored while busy=1
a_src_flat  in  DATA_W*E  A elements; element i at [i*DATA_W +: DATA_W]
b_src_flat  in  DATA_W*E  B elements, same layout as A
c_res_flat  out  SUM_W*E  captured C results; element i at [i*SUM_W +: SUM_W]
busy  out  1  job in progress
job_done  out  1  one-cycle pulse when a job ends (success or error)
err_timeout  out  1  sticky flag; polling exceeded POLL_TIMEOUT
err_id  out  1  sticky flag; ID mismatch (only with the optional feature)
mmio_wr  out  1  write request
mmio_rd  out  1  read request
mmio_addr  out  16  byte address
mmio_wdata  out  32  write data
mmio_wstrb  out  4  4'hF on writes, 4'h0 otherwise
mmio_rdata  in  32  read data; valid in the same cycle as mmio_rd && mmio_ready
mmio_ready  in  1  access completes in any cycle where the request and ready are both high

Behaviour:
- Register map: A at TPU_BASE+0x100+i; B at TPU_BASE+0x200+i; C at TPU_BASE+0x300+4*i; CTRL at TPU_BASE+0x8; STATUS at TPU_BASE+0xC (bit1 = done, bit0 = busy); ID at TPU_BASE+0x0.
- Reset (async): state IDLE. All outputs 0: mmio_wr, mmio_rd, mmio_addr, mmio_wdata, mmio_wstrb, busy, job_done, both err flags, c_res_flat. Mid-job reset drops the request in the same instant; no partial completion is recorded.
- All bus outputs are registered. Request, address and data are held stable until the cycle where mmio_ready=1; the next request may be issued in the following cycle, so back-to-back accesses run one per cycle when ready is tied high.
- FSM: IDLE -> [CHK_ID] -> WR_A -> WR_B -> START -> POLL -> SETTLE -> RD_C -> CLEAR -> IDLE.
  - IDLE: on job_start, set busy=1 and clear both err flags; the first request appears on the next cycle.
  - WR_A / WR_B: index 0..E-1. mmio_wdata is the element zero-extended to 32 bits. Advance the index on each completed access; move to the next state after index E-1 completes.
  - START: write 32'h1 to CTRL.
  - POLL: read STATUS. If rdata[1]=1 on a completed access, go to SETTLE. Otherwise increment the poll counter. When the counter reaches POLL_TIMEOUT, set err_timeout and go to CLEAR; no C reads occur in this case.
  - SETTLE: no requests for SETTLE_CYCLES cycles. This covers the accelerator capturing sums one cycle after done.
  - RD_C: read C element i and store mmio_rdata into c_res_flat element i in the cycle the access completes. Index runs 0..E-1.
  - CLEAR: write 32'h2 to CTRL. On completion: busy=0, job_done pulses for 1 cycle, return to IDLE.
- c_res_flat holds its values until the next successful RD_C overwrites them.
- job_start is ignored while busy=1. job_start in the same cycle as job_done returning to IDLE is also ignored.
- Latency with mmio_ready tied high and done seen on poll k (counting from 1): 1 + 2E + 1 + k + SETTLE_CYCLES + E + 1 cycles from job_start to job_done.

Optional Feature:
TPU_HOST_ID_CHECK_EN
- Defined: IDLE goes to CHK_ID, which performs one read of ID. On mismatch with EXPECT_ID, set err_id, skip directly to job_done and return to IDLE; no writes are issued. On match, continue to WR_A.
- Undefined: the CHK_ID state is absent, err_id is tied to 0, and IDLE goes directly to WR_A.

Test Plan:
1. N=4, A=identity, B[i]=i+1, accelerator model attached, mmio_ready=1 -> c_res_flat[i]=i+1; exactly 16+16 writes plus CTRL 0x1 and 0x2 observed in order; job_done pulses once.
2. mmio_ready randomly low 50% of cycles -> request, address and data are held stable while ready=0; results identical to scenario 1.
3. STATUS model never sets done, POLL_TIMEOUT=8 -> exactly 8 STATUS reads, err_timeout=1, CTRL 0x2 written, no C reads, job_done pulses.
4. job_start re-pulsed during WR_B -> no restart; the address sequence is unchanged.
5. rst_n asserted during RD_C index 5 -> mmio_rd and busy drop immediately and all outputs return to 0; a new job after reset completes correctly.
6. With TPU_HOST_ID_CHECK_EN defined and ID model returning 32'hDEAD_BEEF -> one ID read, then err_id=1 and job_done pulses, with zero writes.
